// File: rtl/banner_pkg.sv
// Shared types and constants for the banner scroller.
//   state_e : scroll state machine states
//   ROM_W   : char-ROM width in columns (offset wraps at this value)
//   ROM_H   : char-ROM height in rows (unscaled band height)
package banner_pkg;

  typedef enum logic [1:0] {
    STOP,
    SCROLL,
    PAUSE
  } state_e;

  localparam int unsigned ROM_W = 128;
  localparam int unsigned ROM_H = 28;

endpackage

// File: rtl/banner_scroller_if.sv
// Char-ROM lookup bus between the banner scroller and the ROM.
//   rom_xaddr : column address (7 bits)
//   rom_yaddr : row address (5 bits)
//   rom_data  : colour index, combinational from the addresses
// master = scroller side, slave = ROM side.
interface banner_scroller_if;

  logic [6:0] rom_xaddr;
  logic [4:0] rom_yaddr;
  logic [2:0] rom_data;

  modport master (
    output rom_xaddr,
    output rom_yaddr,
    input  rom_data
  );

  modport slave (
    input  rom_xaddr,
    input  rom_yaddr,
    output rom_data
  );

endinterface

// File: rtl/scroll_fsm.sv
// Horizontal scroll state machine. Advances the banner offset once per frame and
// holds it for PAUSE_FRAMES frames after each horizontal wrap.
//   clk, rst_n : clock, asynchronous active-low reset
//   frame_tick : one-cycle pulse per frame; all state changes happen only here
//   run        : scroll enable
//   speed      : columns advanced per frame (sampled on frame_tick only)
//   offset     : current column offset into the char ROM
//   paused     : high while in PAUSE
module scroll_fsm
  import banner_pkg::*;
#(
  parameter int unsigned PAUSE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       run,
  input  logic [2:0] speed,
  output logic [6:0] offset,
  output logic       paused
);

  localparam int unsigned CntW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(PAUSE_FRAMES - 1);

  state_e          state_q, state_d;
  logic [6:0]      offset_q, offset_d;
  logic [CntW-1:0] pause_cnt_q, pause_cnt_d;
  logic [7:0]      sum;

  // Bit 7 of the sum flags a wrap past the end of the ROM.
  assign sum = {1'b0, offset_q} + {5'b0, speed};

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    pause_cnt_d = pause_cnt_q;
    if (frame_tick) begin
      case (state_q)
        STOP: begin
          if (run) state_d = SCROLL;
        end
        SCROLL: begin
          if (!run) begin
            state_d = STOP;
          end else begin
            offset_d = sum[6:0];
            if (sum[7]) begin
              state_d     = PAUSE;
              pause_cnt_d = CntLoad;
            end
          end
        end
        PAUSE: begin
          if (!run) begin
            state_d     = STOP;
            pause_cnt_d = '0;
          end else if (pause_cnt_q == '0) begin
            state_d = SCROLL;
          end else begin
            pause_cnt_d = pause_cnt_q - 1'b1;
          end
        end
        default: state_d = STOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STOP;
      offset_q    <= '0;
      pause_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      pause_cnt_q <= pause_cnt_d;
    end
  end

  assign offset = offset_q;
  assign paused = (state_q == PAUSE);

endmodule

// File: rtl/banner_scroller.sv
// Scrolling text banner overlay. Maps the beam position into char-ROM addresses
// inside a horizontal band and returns the ROM colour as a palette index, with a
// fixed two-cycle latency from hpos/vpos to pix_color/pix_opaque.
//   clk, rst_n         : clock, asynchronous active-low reset
//   hpos, vpos         : current beam column / line
//   frame_tick         : once-per-frame pulse (vblank) driving the scroll FSM
//   run, speed         : scroll enable and columns per frame
//   rom                : char-ROM bus (master side)
//   pix_color          : palette index, 0 outside the band
//   pix_opaque         : banner pixel present (in band, non-zero colour)
//   paused             : scroll FSM is holding after a wrap
module banner_scroller
  import banner_pkg::*;
#(
  parameter int unsigned BAND_Y       = 200,
  parameter int unsigned SCALE_SHIFT  = 1,
  parameter int unsigned PAUSE_FRAMES = 60
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [9:0]                hpos,
  input  logic [9:0]                vpos,
  input  logic                      frame_tick,
  input  logic                      run,
  input  logic [2:0]                speed,
  banner_scroller_if.master         rom,
  output logic [2:0]                pix_color,
  output logic                      pix_opaque,
  output logic                      paused
);

  localparam int unsigned BandEnd = BAND_Y + (ROM_H << SCALE_SHIFT);

  logic [6:0] offset;

  scroll_fsm #(
    .PAUSE_FRAMES(PAUSE_FRAMES)
  ) u_scroll_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .run       (run),
    .speed     (speed),
    .offset    (offset),
    .paused    (paused)
  );

  // Stage 1: band decode and ROM address generation.
  logic       in_band;
  logic       in_band_q, in_band_d;
  logic [6:0] xaddr_q, xaddr_d;
  logic [4:0] yaddr_q, yaddr_d;

  // Stage 2: colour from the ROM, gated by the delayed band flag.
  logic [2:0] color_q, color_d;
  logic       opaque_q, opaque_d;

  assign in_band = (32'(vpos) >= BAND_Y) && (32'(vpos) < BandEnd);

  always_comb begin
    in_band_d = in_band;
    xaddr_d   = '0;
    yaddr_d   = '0;
    if (in_band) begin
      // The 7-bit add wraps the column naturally at ROM_W.
      xaddr_d = 7'(hpos >> SCALE_SHIFT) + offset;
      yaddr_d = 5'((vpos - 10'(BAND_Y)) >> SCALE_SHIFT);
    end
    color_d  = in_band_q ? rom.rom_data : 3'd0;
    opaque_d = in_band_q && (rom.rom_data != 3'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_band_q <= 1'b0;
      xaddr_q   <= '0;
      yaddr_q   <= '0;
      color_q   <= '0;
      opaque_q  <= 1'b0;
    end else begin
      in_band_q <= in_band_d;
      xaddr_q   <= xaddr_d;
      yaddr_q   <= yaddr_d;
      color_q   <= color_d;
      opaque_q  <= opaque_d;
    end
  end

  assign rom.rom_xaddr = xaddr_q;
  assign rom.rom_yaddr = yaddr_q;
  assign pix_color     = color_q;
  assign pix_opaque    = opaque_q;

endmodule

// File: tb/tb_banner_scroller.sv
// Self-checking bench for banner_scroller (BAND_Y=200, SCALE_SHIFT=1, PAUSE_FRAMES=60).
// Pixel-path expectations go through a two-stage scoreboard; scroll behaviour is
// checked against fixed offset/paused values.
module tb_banner_scroller;

  typedef struct packed {
    logic [6:0] xa;
    logic [4:0] ya;
    logic [2:0] col;
    logic       op;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic       frame_tick = 1'b0;
  logic       run = 1'b0;
  logic [2:0] speed = '0;
  logic [2:0] pix_color;
  logic       pix_opaque;
  logic       paused;

  logic       rom_force_en = 1'b0;
  logic [2:0] rom_force = '0;
  logic [6:0] m_off = '0;

  int total = 0;
  int bad = 0;

  exp_t addr_q[$];
  exp_t pix_q[$];

  banner_scroller_if rom_if ();

  banner_scroller #(
    .BAND_Y      (200),
    .SCALE_SHIFT (1),
    .PAUSE_FRAMES(60)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hpos      (hpos),
    .vpos      (vpos),
    .frame_tick(frame_tick),
    .run       (run),
    .speed     (speed),
    .rom       (rom_if),
    .pix_color (pix_color),
    .pix_opaque(pix_opaque),
    .paused    (paused)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_fn(input logic [6:0] x, input logic [4:0] y);
    return x[2:0] ^ y[2:0] ^ x[5:3];
  endfunction

  always_comb begin
    rom_if.rom_data = rom_force_en ? rom_force : rom_fn(rom_if.rom_xaddr, rom_if.rom_yaddr);
  end

  // One beam cycle: retire scoreboard entries, then drive (and optionally expect) h/v.
  task automatic step(input bit push, input logic [9:0] h, input logic [9:0] v);
    exp_t e;
    exp_t p;
    bit   inb;
    @(negedge clk);
    if (pix_q.size() > 0) begin
      p = pix_q.pop_front();
      total++;
      if (pix_color !== p.col || pix_opaque !== p.op) begin
        bad++;
        $display("FAIL pixel: got color=%0d opaque=%0d want color=%0d opaque=%0d",
                 pix_color, pix_opaque, p.col, p.op);
      end
    end
    if (addr_q.size() > 0) begin
      p = addr_q.pop_front();
      total++;
      if (rom_if.rom_xaddr !== p.xa || rom_if.rom_yaddr !== p.ya) begin
        bad++;
        $display("FAIL addr: got x=%0d y=%0d want x=%0d y=%0d",
                 rom_if.rom_xaddr, rom_if.rom_yaddr, p.xa, p.ya);
      end
      pix_q.push_back(p);
    end
    hpos = h;
    vpos = v;
    if (push) begin
      inb  = (v >= 10'd200) && (v < 10'd256);
      e.xa = inb ? 7'(7'(h >> 1) + m_off) : 7'd0;
      e.ya = inb ? 5'((v - 10'd200) >> 1) : 5'd0;
      e.col = inb ? (rom_force_en ? rom_force : rom_fn(e.xa, e.ya)) : 3'd0;
      e.op = (e.col != 3'd0);
      addr_q.push_back(e);
    end
  endtask

  task automatic flush();
    step(1'b0, hpos, vpos);
    step(1'b0, hpos, vpos);
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Offset probe: hpos=0, vpos=200 held, so rom_xaddr shows the live offset.
  task automatic tick_check(input string name, input logic [6:0] exp_x, input logic exp_p);
    tick();
    @(negedge clk);
    total++;
    if (rom_if.rom_xaddr !== exp_x || paused !== exp_p) begin
      bad++;
      $display("FAIL %s: got offset=%0d paused=%0d want offset=%0d paused=%0d",
               name, rom_if.rom_xaddr, paused, exp_x, exp_p);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (rom_if.rom_xaddr !== 7'd0 || rom_if.rom_yaddr !== 5'd0 || pix_color !== 3'd0 ||
        pix_opaque !== 1'b0 || paused !== 1'b0) begin
      bad++;
      $display("FAIL reset: got x=%0d y=%0d col=%0d op=%0d paused=%0d want all 0",
               rom_if.rom_xaddr, rom_if.rom_yaddr, pix_color, pix_opaque, paused);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_band();
    m_off = 7'd0;
    rom_force_en = 1'b1;
    rom_force = 3'd3;
    step(1'b1, 10'd10, 10'd200);
    step(1'b1, 10'd0, 10'd255);
    step(1'b1, 10'd0, 10'd256);
    step(1'b1, 10'd0, 10'd199);
    flush();
    rom_force = 3'd0;
    step(1'b1, 10'd4, 10'd210);
    flush();
    rom_force_en = 1'b0;
    step(1'b1, 10'd100, 10'd230);
    step(1'b1, 10'd639, 10'd240);
    step(1'b1, 10'd57, 10'd201);
    flush();
  endtask

  task automatic test_scroll();
    step(1'b0, 10'd0, 10'd200);
    run = 1'b1;
    speed = 3'd4;
    tick_check("scroll_t1", 7'd0, 1'b0);
    tick_check("scroll_t2", 7'd4, 1'b0);
    tick_check("scroll_t3", 7'd8, 1'b0);
    tick_check("scroll_t4", 7'd12, 1'b0);
  endtask

  task automatic test_wrap_pause();
    speed = 3'd6;
    for (int i = 0; i < 19; i++) tick();
    @(negedge clk);
    total++;
    if (rom_if.rom_xaddr !== 7'd126) begin
      bad++;
      $display("FAIL pre_wrap: got offset=%0d want 126", rom_if.rom_xaddr);
    end
    speed = 3'd3;
    tick_check("wrap", 7'd1, 1'b1);
    for (int i = 0; i < 59; i++) tick_check("pause_hold", 7'd1, 1'b1);
    tick_check("pause_exit", 7'd1, 1'b0);
    tick_check("resume", 7'd4, 1'b0);
  endtask

  task automatic test_stop_in_pause();
    speed = 3'd7;
    for (int i = 0; i < 17; i++) tick();
    tick_check("wrap2", 7'd2, 1'b1);
    run = 1'b0;
    tick_check("pause_stop", 7'd2, 1'b0);
    run = 1'b1;
    speed = 3'd1;
    tick_check("stop_start", 7'd2, 1'b0);
    repeat (3) @(negedge clk);
    speed = 3'd5;
    repeat (3) @(negedge clk);
    total++;
    if (rom_if.rom_xaddr !== 7'd2) begin
      bad++;
      $display("FAIL midframe_speed: got offset=%0d want 2", rom_if.rom_xaddr);
    end
    tick_check("speed_sampled", 7'd7, 1'b0);
    m_off = 7'd7;
  endtask

  task automatic test_back_to_back();
    rom_force_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 10'($urandom_range(0, 1023)), 10'($urandom_range(190, 262)));
    end
    flush();
  endtask

  task automatic test_reset_mid();
    rom_force_en = 1'b1;
    rom_force = 3'd5;
    step(1'b1, 10'd20, 10'd220);
    flush();
    total++;
    if (pix_opaque !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_opaque: got %0d want 1", pix_opaque);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (rom_if.rom_xaddr !== 7'd0 || rom_if.rom_yaddr !== 5'd0 || pix_color !== 3'd0 ||
        pix_opaque !== 1'b0 || paused !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got x=%0d y=%0d col=%0d op=%0d paused=%0d want all 0",
               rom_if.rom_xaddr, rom_if.rom_yaddr, pix_color, pix_opaque, paused);
    end
    addr_q.delete();
    pix_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    m_off = 7'd0;
    rom_force_en = 1'b0;
    step(1'b1, 10'd0, 10'd200);
    step(1'b1, 10'd10, 10'd202);
    step(1'b1, 10'd0, 10'd200);
    flush();
    speed = 3'd2;
    tick_check("post_reset_start", 7'd0, 1'b0);
    tick_check("post_reset_scroll", 7'd2, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_band();
    test_scroll();
    test_wrap_pause();
    test_stop_in_pause();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/banner_scroller.md
BANNER_SCROLLER -- requirements
Module: banner_scroller

Interface
REQ-001 SHALL have parameter BAND_Y, default 200: first screen line of the banner band.
REQ-002 SHALL have parameter SCALE_SHIFT, default 1: log2 pixel magnification, applied to both axes.
REQ-003 SHALL have parameter PAUSE_FRAMES, default 60: frames the banner holds after each horizontal wrap.
REQ-004 SHALL have port clk, input, 1: sole clock.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port hpos, input, 10: current pixel column.
REQ-007 SHALL have port vpos, input, 10: current pixel line.
REQ-008 SHALL have port frame_tick, input, 1: one-cycle pulse, once per frame, in vblank.
REQ-009 SHALL have port run, input, 1: scroll enable.
REQ-010 SHALL have port speed, input, 3: columns advanced per frame.
REQ-011 SHALL have port rom_xaddr, output, 7: char-ROM column address.
REQ-012 SHALL have port rom_yaddr, output, 5: char-ROM row address.
REQ-013 SHALL have port rom_data, input, 3: char-ROM colour index, combinational from the addresses.
REQ-014 SHALL have port pix_color, output, 3: palette index to the palette block.
REQ-015 SHALL have port pix_opaque, output, 1: banner pixel present.
REQ-016 SHALL have port paused, output, 1: high while in PAUSE.

Function
REQ-017 SHALL treat vpos as in band when BAND_Y <= vpos < BAND_Y + (28 << SCALE_SHIFT).
REQ-018 SHALL register rom_yaddr = (vpos - BAND_Y) >> SCALE_SHIFT and rom_xaddr = ((hpos >> SCALE_SHIFT) + offset) mod 128 one cycle after hpos/vpos, when in band.
REQ-019 SHALL drive rom_xaddr = 0 and rom_yaddr = 0 one cycle after an out-of-band hpos/vpos.
REQ-020 SHALL register, two cycles after hpos/vpos: pix_color = rom_data if in band, else 0; pix_opaque = in band AND rom_data != 0.
REQ-021 SHALL delay the in-band flag one stage so it stays aligned with the address pipeline; total latency is fixed at 2 cycles.
REQ-022 SHALL keep a 7-bit offset and a state machine with states STOP, SCROLL and PAUSE, evaluated only on frame_tick.
REQ-023 STOP: on frame_tick with run=1, SHALL go to SCROLL with offset unchanged.
REQ-024 SCROLL: on frame_tick with run=0, SHALL go to STOP.
REQ-025 SCROLL: on frame_tick with run=1, SHALL compute sum = offset + speed (8 bits) and set offset = sum[6:0].
REQ-026 SCROLL: if sum >= 128, SHALL go to PAUSE with pause_cnt = PAUSE_FRAMES-1.
REQ-027 SCROLL: speed = 0 SHALL leave offset unchanged and the state in SCROLL.
REQ-028 PAUSE: offset SHALL stay frozen.
REQ-029 PAUSE: on frame_tick with run=0, SHALL go to STOP and clear pause_cnt.
REQ-030 PAUSE: on frame_tick with run=1 and pause_cnt = 0, SHALL go to SCROLL; otherwise pause_cnt SHALL decrement.
REQ-031 SHALL sample speed only on frame_tick; changes between ticks have no effect.
REQ-032 SHALL apply an offset update to the address path from the cycle after frame_tick.
REQ-033 SHALL drive paused = 1 exactly while state = PAUSE.

Reset
REQ-034 On rst_n low, SHALL immediately set state = STOP and clear offset, pause_cnt, pipeline flags, rom_xaddr, rom_yaddr, pix_color, pix_opaque and paused to 0, mid-frame included.
REQ-035 After rst_n rises, SHALL produce the first valid pix_color 2 cycles later.

Structure
REQ-036 Shared package banner_pkg SHALL hold the state enum (STOP, SCROLL, PAUSE) and constants ROM_W = 128 and ROM_H = 28.
REQ-037 SHALL place the offset/pause state machine in one sub-module, scroll_fsm, with outputs offset and paused; band mapping and the pixel pipeline stay in banner_scroller.

Verification (BAND_Y=200, SCALE_SHIFT=1, PAUSE_FRAMES=60)
REQ-038 After reset, hpos=10, vpos=200 -> rom_xaddr=5, rom_yaddr=0 at +1; with rom_data=3, pix_color=3, pix_opaque=1 at +2.
REQ-039 vpos=255 -> rom_yaddr=27; vpos=256 or 199 -> addresses 0, pix_color=0, pix_opaque=0; in-band rom_data=0 -> pix_opaque=0.
REQ-040 run=1, speed=4, four frame_ticks -> offset 0,4,8,12; then hpos=0, vpos=200 -> rom_xaddr=12.
REQ-041 offset=126, speed=3, frame_tick -> offset=1, paused=1; offset stays 1 for 60 ticks; the 60th tick returns to SCROLL and the 61st gives offset=4.
REQ-042 run=0 during PAUSE, frame_tick -> STOP, paused=0, offset held; speed changed mid-frame -> no offset change until the next tick.
REQ-043 rst_n low mid-band while pix_opaque=1 -> all outputs 0 the same cycle, state STOP, offset 0.
